alu_instr_sequencer: RTL and testbench

- Hardware control unit driving the CPU datapath's control inputs for register-to-register ALU instructions, replacing bench-generated control sequences.
- Fetches via PC/MAR/MDR, loads IR, decodes opcode and register fields, then steps the T-states that move operands through Y, the ALU, Z, HI/LO and the register file.
- Sits beside the datapath: its outputs connect one-to-one to the datapath control inputs, and IR is fed back from the datapath.

---
 rtl/alu_instr_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Control sequencer for register-to-register ALU instructions: fetch, decode, then T-state control decode.
// Optional MEM_WAIT_EN adds a T0W wait state that holds the memory read until mem_ready.
module alu_instr_sequencer #(
  parameter int unsigned NREGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [31:0]       IR,
  input  logic              mem_ready,
  output logic [NREGS-1:0]  R_out,
  output logic [NREGS-1:0]  R_in,
  output logic              HIout,
  output logic              LOout,
  output logic              Zhighout,
  output logic              Zlowout,
  output logic              PCout,
  output logic              MDRout,
  output logic              HIin,
  output logic              LOin,
  output logic              PCin,
  output logic              IRin,
  output logic              Zin,
  output logic              Yin,
  output logic              MARin,
  output logic              MDRin,
  output logic              Read,
  output logic              IncPC,
  output logic [12:0]       alu_op,
  output logic [3:0]        state,
  output logic              instr_done,
  output logic              illegal_op
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 4;
  localparam int unsigned ALU_W = 13;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T0W  = 4'd2,
    S_T1   = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7
  } state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] ra, rb, rc;
  logic             is_3op, is_muldiv, is_unary;
  logic [ALU_W-1:0] alu_sel;
  state_e           after_final;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  // Low IR bits (and mem_ready without the wait feature) carry no control information.
  logic unused_c;
`ifdef MEM_WAIT_EN
  assign unused_c = ^IR[14:0];
`else
  assign unused_c = ^{IR[14:0], mem_ready};
`endif

  function automatic logic [NREGS-1:0] reg_sel(input logic [REG_W-1:0] idx);
    reg_sel = NREGS'(1) << idx;
  endfunction

  // Opcode class and one-hot ALU function, bit 12 = AND down to bit 0 = NOT.
  always_comb begin
    is_3op    = 1'b0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    alu_sel   = '0;
    unique case (opcode)
      5'd3:  begin is_3op    = 1'b1; alu_sel[10] = 1'b1; end
      5'd4:  begin is_3op    = 1'b1; alu_sel[9]  = 1'b1; end
      5'd5:  begin is_3op    = 1'b1; alu_sel[12] = 1'b1; end
      5'd6:  begin is_3op    = 1'b1; alu_sel[11] = 1'b1; end
      5'd7:  begin is_3op    = 1'b1; alu_sel[3]  = 1'b1; end
      5'd8:  begin is_3op    = 1'b1; alu_sel[2]  = 1'b1; end
      5'd9:  begin is_3op    = 1'b1; alu_sel[6]  = 1'b1; end
      5'd10: begin is_3op    = 1'b1; alu_sel[5]  = 1'b1; end
      5'd11: begin is_3op    = 1'b1; alu_sel[4]  = 1'b1; end
      5'd15: begin is_muldiv = 1'b1; alu_sel[7]  = 1'b1; end
      5'd16: begin is_muldiv = 1'b1; alu_sel[8]  = 1'b1; end
      5'd17: begin is_unary  = 1'b1; alu_sel[1]  = 1'b1; end
      5'd18: begin is_unary  = 1'b1; alu_sel[0]  = 1'b1; end
      default: ;
    endcase
  end

  assign after_final = run ? S_T0 : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and control decode from the current state plus IR fields.
  always_comb begin
    state_d    = state_q;
    R_out      = '0;
    R_in       = '0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    Zhighout   = 1'b0;
    Zlowout    = 1'b0;
    PCout      = 1'b0;
    MDRout     = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    Zin        = 1'b0;
    Yin        = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    Read       = 1'b0;
    IncPC      = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        IncPC = 1'b1;
        PCin  = 1'b1;
        MARin = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
`ifdef MEM_WAIT_EN
        state_d = mem_ready ? S_T1 : S_T0W;
`else
        state_d = S_T1;
`endif
      end
      S_T0W: begin
`ifdef MEM_WAIT_EN
        // Only the read is held; PC update and MAR load already happened in T0.
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = mem_ready ? S_T1 : S_T0W;
`else
        state_d = S_IDLE;
`endif
      end
      S_T1: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        if (is_3op) begin
          R_out   = reg_sel(rb);
          Yin     = 1'b1;
          state_d = S_T3;
        end else if (is_muldiv) begin
          R_out   = reg_sel(ra);
          Yin     = 1'b1;
          state_d = S_T3;
        end else if (is_unary) begin
          R_out   = reg_sel(rb);
          alu_op  = alu_sel;
          Zin     = 1'b1;
          state_d = S_T3;
        end else begin
          illegal_op = 1'b1;
          state_d    = after_final;
        end
      end
      S_T3: begin
        if (is_3op) begin
          R_out   = reg_sel(rc);
          alu_op  = alu_sel;
          Zin     = 1'b1;
          state_d = S_T4;
        end else if (is_muldiv) begin
          R_out   = reg_sel(rb);
          alu_op  = alu_sel;
          Zin     = 1'b1;
          state_d = S_T4;
        end else begin
          Zlowout    = 1'b1;
          R_in       = reg_sel(ra);
          instr_done = 1'b1;
          state_d    = after_final;
        end
      end
      S_T4: begin
        Zlowout = 1'b1;
        if (is_3op) begin
          R_in       = reg_sel(ra);
          instr_done = 1'b1;
          state_d    = after_final;
        end else begin
          LOin    = 1'b1;
          state_d = S_T5;
        end
      end
      S_T5: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
        state_d    = after_final;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = 4'(state_q);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: directed spec sequences, random instruction stream,
// a small datapath model for the DIV result, and mid-instruction reset.
module tb_alu_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] R_out, R_in;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Read, IncPC;
  logic [12:0] alu_op;
  logic [3:0]  state;
  logic        instr_done, illegal_op;

  alu_instr_sequencer #(.NREGS(16)) dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR), .mem_ready(mem_ready),
    .R_out(R_out), .R_in(R_in),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .Read(Read), .IncPC(IncPC),
    .alu_op(alu_op), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-bit controls packed in a fixed order for whole-cycle comparison.
  localparam logic [15:0] C_INCPC  = 16'h0001;
  localparam logic [15:0] C_READ   = 16'h0002;
  localparam logic [15:0] C_MDRIN  = 16'h0004;
  localparam logic [15:0] C_MARIN  = 16'h0008;
  localparam logic [15:0] C_YIN    = 16'h0010;
  localparam logic [15:0] C_ZIN    = 16'h0020;
  localparam logic [15:0] C_IRIN   = 16'h0040;
  localparam logic [15:0] C_PCIN   = 16'h0080;
  localparam logic [15:0] C_LOIN   = 16'h0100;
  localparam logic [15:0] C_HIIN   = 16'h0200;
  localparam logic [15:0] C_MDROUT = 16'h0400;
  localparam logic [15:0] C_ZLOUT  = 16'h1000;
  localparam logic [15:0] C_ZHOUT  = 16'h2000;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [12:0] alu;
    logic [15:0] sig;
    logic        done;
    logic        ill;
  } ctl_t;

  int   checks = 0;
  int   errors = 0;
  ctl_t exp_q[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    ctl_t c;
    c.st   = state;
    c.rout = R_out;
    c.rin  = R_in;
    c.alu  = alu_op;
    c.sig  = {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, HIin, LOin,
              PCin, IRin, Zin, Yin, MARin, MDRin, Read, IncPC};
    c.done = instr_done;
    c.ill  = illegal_op;
    return c;
  endfunction

  function automatic ctl_t mk(input logic [3:0] st, input logic [15:0] sig);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.sig = sig;
    return c;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    return 16'(1) << i;
  endfunction

  // ALU one-hot position by opcode: {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}.
  function automatic int alu_bit(input int op);
    case (op)
      5: return 12;  6: return 11;  3: return 10;  4: return 9;
      16: return 8;  15: return 7;  9: return 6;   10: return 5;
      11: return 4;  7: return 3;   8: return 2;   17: return 1;
      18: return 0;
      default: return -1;
    endcase
  endfunction

  // Instruction class: 3 = three-operand, 2 = mul/div, 1 = neg/not, 0 = illegal.
  function automatic int op_class(input int op);
    if (op >= 3 && op <= 11) return 3;
    if (op == 15 || op == 16) return 2;
    if (op == 17 || op == 18) return 1;
    return 0;
  endfunction

  // Expected per-cycle control words for one fetch/execute of ir.
  function automatic void build(input logic [31:0] ir, input int nwait);
    ctl_t        c;
    int          op;
    logic [3:0]  ra, rb, rc;
    logic [12:0] a;
    op = int'(ir[31:27]);
    ra = ir[26:23];
    rb = ir[22:19];
    rc = ir[18:15];
    a  = (alu_bit(op) >= 0) ? (13'(1) << alu_bit(op)) : 13'd0;
    exp_q.delete();
    exp_q.push_back(mk(4'd1, C_INCPC | C_PCIN | C_MARIN | C_READ | C_MDRIN));
    for (int k = 0; k < nwait; k++) exp_q.push_back(mk(4'd2, C_READ | C_MDRIN));
    exp_q.push_back(mk(4'd3, C_MDROUT | C_IRIN));
    case (op_class(op))
      3: begin
        c = mk(4'd4, C_YIN);   c.rout = oh(rb); exp_q.push_back(c);
        c = mk(4'd5, C_ZIN);   c.rout = oh(rc); c.alu = a; exp_q.push_back(c);
        c = mk(4'd6, C_ZLOUT); c.rin = oh(ra);  c.done = 1'b1; exp_q.push_back(c);
      end
      2: begin
        c = mk(4'd4, C_YIN);   c.rout = oh(ra); exp_q.push_back(c);
        c = mk(4'd5, C_ZIN);   c.rout = oh(rb); c.alu = a; exp_q.push_back(c);
        exp_q.push_back(mk(4'd6, C_ZLOUT | C_LOIN));
        c = mk(4'd7, C_ZHOUT | C_HIIN); c.done = 1'b1; exp_q.push_back(c);
      end
      1: begin
        c = mk(4'd4, C_ZIN);   c.rout = oh(rb); c.alu = a; exp_q.push_back(c);
        c = mk(4'd5, C_ZLOUT); c.rin = oh(ra);  c.done = 1'b1; exp_q.push_back(c);
      end
      default: begin
        c = mk(4'd4, 16'h0); c.ill = 1'b1; exp_q.push_back(c);
      end
    endcase
  endfunction

  function automatic logic idle_ready();
`ifdef MEM_WAIT_EN
    return 1'b1;
`else
    return 1'($urandom % 2);
`endif
  endfunction

  // Steps one instruction from T0; abort_at >= 0 pulls reset low after that cycle.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic run_next,
                           input int nwait, input int abort_at);
    int n;
    build(ir, nwait);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, i), 96'(obs()), 96'(exp_q[i]));
      if (exp_q[i].st == 4'd3) IR = ir;
      mem_ready = (nwait > 0) ? (i >= nwait) : idle_ready();
      if (i == n - 1) run = run_next;
      if (i == abort_at) begin
        #1 reset = 1'b0;
        #1 check($sformatf("%s_abort", name), 96'(obs()), 96'(0));
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", 96'(obs()), 96'(mk(4'd0, 16'h0)));
      IR = $urandom;
      if (i == n - 1) run = 1'b1;
    end
  endtask

  // Minimal datapath so the DIV result can be observed in HI/LO.
  logic [31:0] regs [16];
  logic [31:0] y_r, hi_r, lo_r, bus;
  logic [63:0] z_r;
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  function automatic logic [63:0] alu_f(input logic [12:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    if (f[7]) return (b == 0) ? 64'd0 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    if (f[8]) return 64'($signed(a) * $signed(b));
    if (f[10]) return {32'd0, a + b};
    if (f[9]) return {32'd0, a - b};
    if (f[12]) return {32'd0, a & b};
    if (f[11]) return {32'd0, a | b};
    if (f[1]) return {32'd0, -b};
    if (f[0]) return {32'd0, ~b};
    return 64'd0;
  endfunction

  always_comb begin
    bus = 32'd0;
    for (int i = 0; i < 16; i++) if (R_out[i]) bus = regs[i];
    if (Zlowout) bus = z_r[31:0];
    if (Zhighout) bus = z_r[63:32];
    if (HIout) bus = hi_r;
    if (LOout) bus = lo_r;
  end

  always @(posedge clk) begin
    if (pre_en) regs[pre_idx] <= pre_val;
    if (Yin) y_r <= bus;
    if (Zin) z_r <= alu_f(alu_op, y_r, bus);
    if (LOin) lo_r <= bus;
    if (HIin) hi_r <= bus;
    for (int i = 0; i < 16; i++) if (R_in[i]) regs[i] <= bus;
  end

  initial begin
    int          legal [13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
    logic [4:0]  op;
    logic        rn;
    reset     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b1;
    IR        = 32'd0;
    pre_en    = 1'b1;
    pre_idx   = 4'd2;
    pre_val   = 32'hFFFF_FF14;
    @(negedge clk);
    check("reset0", 96'(obs()), 96'(0));
    pre_idx = 4'd6;
    pre_val = 32'd17;
    run     = 1'b1;
    @(negedge clk);
    check("reset1", 96'(obs()), 96'(0));
    pre_en = 1'b0;
    reset  = 1'b1;

    run_instr("add", 32'h1891_8000, 1'b1, 0, -1);
    run_instr("div", 32'h7930_0000, 1'b0, 0, -1);
    idle(2);
    check("div_lo", 96'(lo_r), 96'(32'hFFFF_FFF3));
    check("div_hi", 96'(hi_r), 96'(32'hFFFF_FFF1));
    run_instr("neg", 32'h8AB8_0000, 1'b0, 0, -1);
    idle(1);
    run_instr("illegal", 32'hF800_0000, 1'b1, 0, -1);
`ifdef MEM_WAIT_EN
    run_instr("wait", 32'h1891_8000, 1'b1, 3, -1);
`endif

    for (int t = 0; t < 40; t++) begin
      op = ($urandom % 5 == 0) ? 5'($urandom) : 5'(legal[$urandom % 13]);
      rn = ($urandom % 4 != 0);
      run_instr($sformatf("rnd%0d_op%0d", t, op), {op, 27'($urandom)}, rn, 0, -1);
      if (!rn) idle(1 + int'($urandom % 3));
    end

    run_instr("div_rst", 32'h7930_0000, 1'b1, 0, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("in_reset", 96'(obs()), 96'(0));
    end
    run   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset", 96'(obs()), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
